// File: rtl/vec_alu_pkg.sv
// rtl/vec_alu_pkg.sv - shared op codes and flag bit positions for vec_alu_pipe
package vec_alu_pkg;

    typedef enum logic [2:0] {
        VADD    = 3'b000,
        DOT     = 3'b001,
        SUB     = 3'b010,
        ADD     = 3'b011,
        CMP     = 3'b100,
        SCALE   = 3'b101,
        MUL     = 3'b110,
        ILLEGAL = 3'b111
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/vec_lane_unit.sv
// rtl/vec_lane_unit.sv - one lane's sum, difference, product and saturated variants
module vec_lane_unit #(
    parameter int LANE_W = 16
) (
    input  logic [LANE_W-1:0]   i_a,
    input  logic [LANE_W-1:0]   i_b,
    input  logic [LANE_W-1:0]   i_b0,
    output logic [LANE_W:0]     o_sum,
    output logic [LANE_W-1:0]   o_diff,
    output logic                o_borrow,
    output logic [2*LANE_W-1:0] o_prod,
    output logic [LANE_W-1:0]   o_sat_sum,
    output logic [LANE_W-1:0]   o_scale,
    output logic [LANE_W-1:0]   o_sat_scale,
    output logic                o_scale_ovf
);

    logic [LANE_W:0]     w_diff;
    logic [2*LANE_W-1:0] w_scale_full;

    assign o_sum        = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff       = {1'b0, i_a} - {1'b0, i_b};
    assign o_diff       = w_diff[LANE_W-1:0];
    assign o_borrow     = w_diff[LANE_W];
    assign o_prod       = {{LANE_W{1'b0}}, i_a} * {{LANE_W{1'b0}}, i_b};
    assign w_scale_full = {{LANE_W{1'b0}}, i_a} * {{LANE_W{1'b0}}, i_b0};
    assign o_scale      = w_scale_full[LANE_W-1:0];
    assign o_scale_ovf  = |w_scale_full[2*LANE_W-1:LANE_W];
    assign o_sat_sum    = o_sum[LANE_W] ? '1 : o_sum[LANE_W-1:0];
    assign o_sat_scale  = o_scale_ovf ? '1 : o_scale;

endmodule

// File: rtl/vec_alu_pipe.sv
// rtl/vec_alu_pipe.sv - two-stage vector/scalar execute ALU with valid/ready handshake
module vec_alu_pipe #(
    parameter int LANES    = 3,
    parameter int LANE_W   = 16,
    parameter int TAG_W    = 5,
    parameter bit SATURATE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              op,
    input  logic [LANES*LANE_W-1:0] opa,
    input  logic [LANES*LANE_W-1:0] opb,
    input  logic [TAG_W-1:0]        tag_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] result,
    output logic [3:0]              flags,
    output logic                    res_we,
    output logic [TAG_W-1:0]        tag_out,
    output logic                    illegal
);
    import vec_alu_pkg::*;

    localparam int W = LANES * LANE_W;

    logic [LANES-1:0][LANE_W:0]     w_sum;
    logic [LANES-1:0][LANE_W-1:0]   w_diff, w_sat_sum, w_scale, w_sat_scale;
    logic [LANES-1:0][LANE_W-1:0]   w_vadd, w_scale_sel;
    logic [LANES-1:0][2*LANE_W-1:0] w_prod;
    logic [LANES-1:0]               w_borrow, w_scale_ovf, w_vadd_c;
    logic [W:0]                     w_ssum;
    logic [W-1:0]                   w_smul;
    logic                           w_s1_adv, w_s2_adv;

    logic                           r_s1_valid;
    alu_op_e                        r_op;
    logic [TAG_W-1:0]               r_tag;
    logic [LANES-1:0][LANE_W-1:0]   r_vadd, r_ldiff, r_scale;
    logic [LANES-1:0][2*LANE_W-1:0] r_prod;
    logic [LANES-1:0]               r_vadd_c, r_lborrow, r_scale_ovf;
    logic [W:0]                     r_ssum;
    logic [W-1:0]                   r_smul;
    logic                           r_a_msb, r_b_msb;

    logic                           r_out_valid, r_res_we, r_illegal;
    logic [W-1:0]                   r_result;
    logic [3:0]                     r_flags;
    logic [TAG_W-1:0]               r_tag_out;

    logic [W-1:0]                   w_dot, w_sdiff, w_res;
    logic                           w_sborrow, w_c, w_v, w_we, w_ill;
    logic [3:0]                     w_flags;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        vec_lane_unit #(.LANE_W(LANE_W)) u_lane (
            .i_a         (opa[gi*LANE_W +: LANE_W]),
            .i_b         (opb[gi*LANE_W +: LANE_W]),
            .i_b0        (opb[LANE_W-1:0]),
            .o_sum       (w_sum[gi]),
            .o_diff      (w_diff[gi]),
            .o_borrow    (w_borrow[gi]),
            .o_prod      (w_prod[gi]),
            .o_sat_sum   (w_sat_sum[gi]),
            .o_scale     (w_scale[gi]),
            .o_sat_scale (w_sat_scale[gi]),
            .o_scale_ovf (w_scale_ovf[gi])
        );
    end

    always_comb begin
        w_vadd      = '0;
        w_vadd_c    = '0;
        w_scale_sel = '0;
        for (int i = 0; i < LANES; i++) begin
            w_vadd[i]      = SATURATE ? w_sat_sum[i] : w_sum[i][LANE_W-1:0];
            w_vadd_c[i]    = w_sum[i][LANE_W];
            w_scale_sel[i] = SATURATE ? w_sat_scale[i] : w_scale[i];
        end
    end

    assign w_ssum = {1'b0, opa} + {1'b0, opb};
    assign w_smul = opa * opb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_op        <= VADD;
            r_tag       <= '0;
            r_vadd      <= '0;
            r_vadd_c    <= '0;
            r_ldiff     <= '0;
            r_lborrow   <= '0;
            r_prod      <= '0;
            r_scale     <= '0;
            r_scale_ovf <= '0;
            r_ssum      <= '0;
            r_smul      <= '0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_op        <= alu_op_e'(op);
                r_tag       <= tag_in;
                r_vadd      <= w_vadd;
                r_vadd_c    <= w_vadd_c;
                r_ldiff     <= w_diff;
                r_lborrow   <= w_borrow;
                r_prod      <= w_prod;
                r_scale     <= w_scale_sel;
                r_scale_ovf <= w_scale_ovf;
                r_ssum      <= w_ssum;
                r_smul      <= w_smul;
                r_a_msb     <= opa[W-1];
                r_b_msb     <= opb[W-1];
            end
        end
    end

    // Lane differences are stitched into the full-width difference by rippling each lane's borrow upward.
    always_comb begin
        logic w_bin;
        w_dot   = '0;
        w_sdiff = '0;
        w_bin   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_dot                        = w_dot + W'(r_prod[i]);
            w_sdiff[i*LANE_W +: LANE_W]  = r_ldiff[i] - LANE_W'(w_bin);
            w_bin                        = r_lborrow[i] | (w_bin & (r_ldiff[i] == '0));
        end
        w_sborrow = w_bin;
    end

    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_we    = 1'b1;
        w_ill   = 1'b0;
        w_flags = '0;
        case (r_op)
            VADD: begin
                w_res = r_vadd;
                w_c   = |r_vadd_c;
            end
            DOT:  w_res = w_dot;
            SUB, CMP: begin
                w_res = w_sdiff;
                w_c   = ~w_sborrow;
                w_v   = (r_a_msb ^ r_b_msb) & (w_sdiff[W-1] ^ r_a_msb);
                w_we  = (r_op == SUB);
            end
            ADD: begin
                w_res = r_ssum[W-1:0];
                w_c   = r_ssum[W];
                w_v   = ~(r_a_msb ^ r_b_msb) & (r_ssum[W-1] ^ r_a_msb);
            end
            SCALE: begin
                w_res = r_scale;
                w_c   = |r_scale_ovf;
            end
            MUL:  w_res = r_smul;
            default: begin
                w_res = '1;
                w_we  = 1'b0;
                w_ill = 1'b1;
            end
        endcase
        if (!w_ill) begin
            w_flags[FLAG_N] = w_res[W-1];
            w_flags[FLAG_Z] = (w_res == '0);
            w_flags[FLAG_C] = w_c;
            w_flags[FLAG_V] = w_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_res_we    <= 1'b0;
            r_tag_out   <= '0;
            r_illegal   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result  <= w_res;
                r_flags   <= w_flags;
                r_res_we  <= w_we;
                r_tag_out <= r_tag;
                r_illegal <= w_ill;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign res_we    = r_res_we;
    assign tag_out   = r_tag_out;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_vec_alu_pipe.sv
// tb/tb_vec_alu_pipe.sv - scoreboard bench for vec_alu_pipe, wrapping and saturating builds side by side
module tb_vec_alu_pipe;

    localparam int LANES  = 3;
    localparam int LANE_W = 16;
    localparam int TAG_W  = 5;
    localparam int W      = LANES * LANE_W;
    localparam longint SMAX = 64'sh0000_7FFF_FFFF_FFFF;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic [W-1:0]     res;
        logic [3:0]       flags;
        logic             we;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [2:0]       op = '0;
    logic [W-1:0]     opa = '0;
    logic [W-1:0]     opb = '0;
    logic [TAG_W-1:0] tag_in = '0;

    logic             in_ready0, out_valid0, res_we0, illegal0;
    logic [W-1:0]     result0;
    logic [3:0]       flags0;
    logic [TAG_W-1:0] tag_out0;
    logic             in_ready1, out_valid1, res_we1, illegal1;
    logic [W-1:0]     result1;
    logic [3:0]       flags1;
    logic [TAG_W-1:0] tag_out1;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    bit   rnd_mode = 1'b0;

    always #5 clk = ~clk;

    vec_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .TAG_W(TAG_W), .SATURATE(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .op(op),
        .opa(opa), .opb(opb), .tag_in(tag_in), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .flags(flags0), .res_we(res_we0), .tag_out(tag_out0), .illegal(illegal0)
    );

    vec_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .TAG_W(TAG_W), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
        .opa(opa), .opb(opb), .tag_in(tag_in), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .flags(flags1), .res_we(res_we1), .tag_out(tag_out1), .illegal(illegal1)
    );

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [TAG_W-1:0] t, input bit sat);
        exp_t        e;
        logic [16:0] s;
        logic [31:0] p;
        logic [95:0] m;
        longint      sa, sb, sd;
        logic        c, v;
        e = '0;
        e.tag = t;
        e.we = 1'b1;
        c = 1'b0;
        v = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: for (int i = 0; i < LANES; i++) begin
                s = 17'(a[i*16 +: 16]) + 17'(b[i*16 +: 16]);
                c = c | s[16];
                e.res[i*16 +: 16] = (sat && s[16]) ? 16'hFFFF : s[15:0];
            end
            3'd1: begin
                m = '0;
                for (int i = 0; i < LANES; i++) m = m + 96'(a[i*16 +: 16]) * 96'(b[i*16 +: 16]);
                e.res = m[W-1:0];
            end
            3'd2, 3'd4: begin
                e.res = a - b;
                c = (a >= b);
                sd = sa - sb;
                v = (sd > SMAX) || (sd < SMIN);
                e.we = (o == 3'd2);
            end
            3'd3: begin
                m = 96'(a) + 96'(b);
                e.res = m[W-1:0];
                c = m[W];
                sd = sa + sb;
                v = (sd > SMAX) || (sd < SMIN);
            end
            3'd5: for (int i = 0; i < LANES; i++) begin
                p = 32'(a[i*16 +: 16]) * 32'(b[15:0]);
                c = c | (p > 32'hFFFF);
                e.res[i*16 +: 16] = (sat && p > 32'hFFFF) ? 16'hFFFF : p[15:0];
            end
            3'd6: begin
                m = 96'(a) * 96'(b);
                e.res = m[W-1:0];
            end
            default: begin
                e.res = '1;
                e.we = 1'b0;
                e.ill = 1'b1;
            end
        endcase
        if (o != 3'd7) e.flags = {e.res[W-1], e.res == '0, c, v};
        return e;
    endfunction

    task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TAG_W-1:0] t);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        op = o;
        opa = a;
        opb = b;
        tag_in = t;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for op %0d tag %0d", o, t);
        end else begin
            q0.push_back(model(o, a, b, t, 1'b0));
            q1.push_back(model(o, a, b, t, 1'b1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out(output bit found);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL wait_out_timeout: out_valid never rose");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) break;
        end
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d/%0d results outstanding, required 0", q0.size(), q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid0, result0, flags0, res_we0, tag_out0, illegal0,
             out_valid1, result1, flags1, res_we1, tag_out1, illegal1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b res=%h flags=%b we=%b tag=%0d ill=%b, required all 0",
                     out_valid0, result0, flags0, res_we0, tag_out0, illegal0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b/%b, required 1", in_ready0, in_ready1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_dot();
        out_ready = 1'b1;
        send(3'd1, {16'd1, 16'd2, 16'd3}, {16'd4, 16'd5, 16'd6}, 5'd1);
        @(negedge clk);
        total++;
        if (out_valid0 !== 1'b0) begin
            bad++;
            $display("FAIL dot_latency_early: out_valid=%b one cycle after accept, required 0", out_valid0);
        end
        @(negedge clk);
        total++;
        if (out_valid0 !== 1'b1) begin
            bad++;
            $display("FAIL dot_latency: out_valid=%b two cycles after accept, required 1", out_valid0);
        end
        total++;
        if ({result0, flags0, res_we0} !== {48'h0000_0000_0020, 4'b0000, 1'b1}) begin
            bad++;
            $display("FAIL dot_result: got res=%h flags=%b we=%b, required 000000000020 0000 1",
                     result0, flags0, res_we0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_vadd();
        bit found;
        send(3'd0, 48'h0000_0000_FFFF, 48'h0000_0000_0002, 5'd2);
        wait_out(found);
        if (found) begin
            total++;
            if ({result0, flags0} !== {48'h0000_0000_0001, 4'b0010}) begin
                bad++;
                $display("FAIL vadd_wrap: got res=%h flags=%b, required 000000000001 0010", result0, flags0);
            end
            total++;
            if ({result1, flags1} !== {48'h0000_0000_FFFF, 4'b0010}) begin
                bad++;
                $display("FAIL vadd_sat: got res=%h flags=%b, required 00000000ffff 0010", result1, flags1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sub();
        bit found;
        send(3'd2, 48'd5, 48'd7, 5'd3);
        wait_out(found);
        if (found) begin
            total++;
            if ({result0, flags0, res_we0} !== {48'hFFFF_FFFF_FFFE, 4'b1000, 1'b1}) begin
                bad++;
                $display("FAIL sub_5_7: got res=%h flags=%b we=%b, required fffffffffffe 1000 1",
                         result0, flags0, res_we0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_cmp();
        bit found;
        send(3'd4, 48'd9, 48'd9, 5'd4);
        wait_out(found);
        if (found) begin
            total++;
            if ({result0, flags0, res_we0} !== {48'd0, 4'b0110, 1'b0}) begin
                bad++;
                $display("FAIL cmp_equal: got res=%h flags=%b we=%b, required 000000000000 0110 0",
                         result0, flags0, res_we0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_illegal();
        bit found;
        send(3'd7, 48'h1234_5678_9ABC, 48'h0F0F_0F0F_0F0F, 5'd5);
        wait_out(found);
        if (found) begin
            total++;
            if ({result0, flags0, res_we0, illegal0} !== {48'hFFFF_FFFF_FFFF, 4'b0000, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL illegal_op: got res=%h flags=%b we=%b ill=%b, required ffffffffffff 0000 0 1",
                         result0, flags0, res_we0, illegal0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(3'd3, 48'h7FFF_FFFF_FFFF, 48'd1, 5'd10);
        send(3'd3, 48'hFFFF_FFFF_FFFF, 48'd1, 5'd11);
        send(3'd5, {16'h0100, 16'h0002, 16'h8000}, 48'd3, 5'd12);
        send(3'd6, 48'h0000_0001_0000, 48'h0000_0001_0003, 5'd13);
        send(3'd2, 48'h8000_0000_0000, 48'd1, 5'd14);
        send(3'd1, {16'hFFFF, 16'hFFFF, 16'hFFFF}, {16'hFFFF, 16'hFFFF, 16'hFFFF}, 5'd15);
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 3'd3; opa = 48'd100; opb = 48'd23; tag_in = 5'd20;
        @(negedge clk);
        total++;
        if (in_ready0 !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept1: in_ready=%b, required 1", in_ready0);
        end
        q0.push_back(model(op, opa, opb, tag_in, 1'b0));
        q1.push_back(model(op, opa, opb, tag_in, 1'b1));
        @(posedge clk);
        #1;
        op = 3'd0; opa = 48'hFFFF_0001_0002; opb = 48'h0001_0002_0003; tag_in = 5'd21;
        @(negedge clk);
        total++;
        if (in_ready0 !== 1'b1) begin
            bad++;
            $display("FAIL bp_accept2: in_ready=%b, required 1", in_ready0);
        end
        q0.push_back(model(op, opa, opb, tag_in, 1'b0));
        q1.push_back(model(op, opa, opb, tag_in, 1'b1));
        @(posedge clk);
        #1;
        op = 3'd5; opa = 48'h0003_0004_0005; opb = 48'd2; tag_in = 5'd22;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total++;
            if ({in_ready0, out_valid0, tag_out0} !== {1'b0, 1'b1, 5'd20}) begin
                bad++;
                $display("FAIL bp_full: got in_ready=%b out_valid=%b tag=%0d, required 0 1 20",
                         in_ready0, out_valid0, tag_out0);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'd5, 48'h0003_0004_0005, 48'd2, 5'd22);
        drain();
    endtask

    task automatic test_random();
        logic [63:0]  ra, rb;
        logic [W-1:0] a, b;
        rnd_mode = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            a = ra[W-1:0];
            b = rb[W-1:0];
            if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFFF;
            if ($urandom_range(0, 3) == 0) b[15:0] = 16'h0000;
            send(3'($urandom_range(0, 7)), a, b, 5'(n));
        end
        rnd_mode = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b0;
        send(3'd6, 48'd12345, 48'd678, 5'd30);
        send(3'd3, 48'd1, 48'd2, 5'd31);
        total++;
        if (out_valid0 !== 1'b1) begin
            bad++;
            $display("FAIL mid_full: out_valid=%b before reset, required 1", out_valid0);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_valid: out_valid=%b/%b during reset, required 0", out_valid0, out_valid1);
        end
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid0 || out_valid1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_stale: %0d stale results after release, required 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && out_valid0 && out_ready) begin
                        total++;
                        if (q0.size() == 0) begin
                            bad++;
                            $display("FAIL sb_wrap_empty: unexpected result %h tag %0d", result0, tag_out0);
                        end else begin
                            e = q0.pop_front();
                            if ({result0, flags0, res_we0, tag_out0, illegal0} !== e) begin
                                bad++;
                                $display("FAIL sb_wrap: got res=%h flags=%b we=%b tag=%0d ill=%b, required res=%h flags=%b we=%b tag=%0d ill=%b",
                                         result0, flags0, res_we0, tag_out0, illegal0,
                                         e.res, e.flags, e.we, e.tag, e.ill);
                            end
                        end
                    end
                    if (rst_n && out_valid1 && out_ready) begin
                        total++;
                        if (q1.size() == 0) begin
                            bad++;
                            $display("FAIL sb_sat_empty: unexpected result %h tag %0d", result1, tag_out1);
                        end else begin
                            e = q1.pop_front();
                            if ({result1, flags1, res_we1, tag_out1, illegal1} !== e) begin
                                bad++;
                                $display("FAIL sb_sat: got res=%h flags=%b we=%b tag=%0d ill=%b, required res=%h flags=%b we=%b tag=%0d ill=%b",
                                         result1, flags1, res_we1, tag_out1, illegal1,
                                         e.res, e.flags, e.we, e.tag, e.ill);
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_dot();
        test_vadd();
        test_sub();
        test_cmp();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_alu_pipe.md
Name: vec_alu_pipe

Overview:
- Parametrised, pipelined vector/scalar ALU for the execute stage of the pipelined CPU; successor to the fixed 3x16-bit, 48-bit execute ALU.
- Generalises lane count and lane width.
- Adds a valid/ready handshake with back-pressure, a tag pass-through, optional saturating lane arithmetic, and correct N/Z/C/V flags.
- Fixed 2-cycle latency from operand acceptance to result.

Parameters:
- LANES, 3, number of vector lanes.
- LANE_W, 16, bits per lane; the data width is W = LANES*LANE_W.
- TAG_W, 5, width of the destination tag carried alongside each operation.
- SATURATE, 0, when 1, vector add and scale clamp each lane to 2^LANE_W-1 instead of wrapping.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  the block accepts the operation this cycle.
- op  in  3  operation code (see Behaviour).
- opa  in  W  operand A; lane i is bits [i*LANE_W +: LANE_W]. Lane LANES-1 is the most significant.
- opb  in  W  operand B, same lane layout.
- tag_in  in  TAG_W  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  W  result.
- flags  out  4  {N,Z,C,V}.
- res_we  out  1  result is to be written back; 0 for CMP and for illegal op codes.
- tag_out  out  TAG_W  tag of the current result.
- illegal  out  1  op code was 3'b111.

Behaviour:
- Reset: asynchronous, active-low, clock is clk.
  - While rst_n=0: out_valid=0, result=0, flags=0, res_we=0, tag_out=0, illegal=0, and both stage valids are 0.
  - Operations in flight are discarded; nothing is emitted after reset is released.
  - in_ready=1 from the first cycle after reset is released.
- Handshake:
  - Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
  - Inputs must be held stable while in_valid=1 and in_ready=0; outputs are held stable while out_valid=1 and out_ready=0.
- Pipeline: S1 (operate) then S2 (reduce/flags, which is also the output register).
  - Advance rules: s2_adv = !out_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
  - Accept at edge k with no stall gives out_valid=1 after edge k+2.
  - Throughput is 1 op/cycle.
  - Capacity is 2 ops; a third op is refused while out_ready=0.
  - Simultaneous accept and emit in one cycle is legal, and the pipeline stays full.
- S1 registers the op code, the tag, and per-lane intermediates: lane sums with carry, lane differences, lane products (2*LANE_W bits each), the scalar sum/difference with carry (W+1 bits), and the scalar product.
- S2 forms the final result and the flags:
  - 000 VADD: result lane i = A_i+B_i mod 2^LANE_W, or saturated when SATURATE=1. C = OR of lane carries. V=0.
  - 001 DOT: result = sum over i of A_i*B_i (unsigned), zero-extended or truncated to W. C=V=0.
  - 010 SUB: result = A-B mod 2^W. C = (A>=B unsigned). V = signed overflow.
  - 011 ADD: result = A+B mod 2^W. C = carry out of bit W-1. V = signed overflow.
  - 100 CMP: flags as for SUB, result = A-B, res_we=0.
  - 101 SCALE: result lane i = A_i*B_0, truncated to the low LANE_W bits, or saturated when SATURATE=1. C = 1 if any lane overflowed. V=0.
  - 110 MUL: result = low W bits of A*B (unsigned). C=V=0.
  - 111: result = all ones, flags=0, res_we=0, illegal=1.
- Flags N and Z, all ops except 111: N = result[W-1], Z = (result==0).
- All arithmetic is unsigned except the V computation.
- Flags are registered together with the result, so there is no combinational path from the operands to the outputs.

Decomposition:
- Package vec_alu_pkg:
  - typedef enum logic[2:0] alu_op_e: VADD, DOT, SUB, ADD, CMP, SCALE, MUL, ILLEGAL.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module vec_lane_unit, instantiated LANES times via generate:
  - Computes one lane's sum with carry, difference, and product.
  - Also computes the saturated variants.

Test Plan (LANES=3, LANE_W=16, SATURATE=0 unless noted):
- DOT, opa={1,2,3}, opb={4,5,6}, out_ready=1 -> 2 cycles later result=0x000000000020, flags=0000, res_we=1.
- VADD, opa lane0=0xFFFF, opb lane0=0x0002, other lanes 0:
  - SATURATE=0 -> lane0=0x0001, C=1.
  - SATURATE=1 -> lane0=0xFFFF.
- SUB, A=5, B=7 -> result=0xFFFFFFFFFFFE, N=1, Z=0, C=0, V=0.
- CMP, A=B=9 -> Z=1, C=1, res_we=0.
- op=111 -> illegal=1, res_we=0, result all ones.
- Back-pressure and reset:
  - Issue 3 back-to-back ops with out_ready=0 -> in_ready=0 after 2 accepts; results emerge in order with their tags once out_ready=1.
  - Assert rst_n=0 mid-stream -> out_valid=0 immediately; no stale results after release.
